frame_dispatch_q: RTL and testbench
===================================

Name: frame_dispatch_q

Overview:
Parametrised, buffered successor of the switch-frame slicing interface. It accepts frames tagged with a one-hot switch-instance select and slices them into addr / wr_rd / wr_data / op_id fields. Frames are queued in a FIFO and dispatched to the selected switch instance with a per-instance ready handshake. sel_en and all fields of a frame are always presented in the same cycle.

Parameters:
NUM_SW_INST, 5, number of switch instances (select/ready width)
W_WIDTH, 8, write-data field width
ADDR_WIDTH, 5, address field width (1..8)
ID_WIDTH, 8, op_id field width
FRAME_WIDTH, 32, input frame width; must be >= ADDR_WIDTH+1+W_WIDTH+ID_WIDTH
FIFO_DEPTH, 4, queue entries; power of 2, >= 2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
load_in  input  NUM_SW_INST  one-hot target select; nonzero = frame offered this cycle
frame_in  input  FRAME_WIDTH  frame: op_id at [ID_WIDTH-1:0], wr_data above it, then wr_rd bit, then addr; upper bits ignored
in_ready  output  1  FIFO can accept a frame
sel_en  output  NUM_SW_INST  one-hot target of presented frame; 0 = nothing presented
addr  output  8  addr field, zero-extended to 8 bits
wr_data  output  W_WIDTH  wr_data field
wr_rd_s  output  1  wr_rd bit (1 = write)
op_id  output  ID_WIDTH  op_id field
out_ready  input  NUM_SW_INST  per-instance ready
fifo_level  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy; excludes the output stage
drop_err  output  1  one-cycle pulse: frame dropped because FIFO full
onehot_err  output  1  one-cycle pulse: frame dropped because load_in had more than one bit set

Behaviour:
- Reset (async): FIFO empty, pointers 0. sel_en, addr, wr_data, wr_rd_s, op_id, fifo_level, drop_err, onehot_err all 0.
- in_ready = (fifo_level != FIFO_DEPTH). It depends on registered state only and has no combinational path from out_ready.
- Offer: load_in != 0 sampled at a clk edge.
- Accepted offer: load_in is one-hot and in_ready=1. The frame is sliced and stored with its select.
- Multi-hot offer: frame discarded, no state change, onehot_err=1 in the next cycle. This check takes priority over the full check.
- Offer while in_ready=0: frame discarded, drop_err=1 in the next cycle. A pop in the same cycle does not rescue it.
- Output stage: a single register holding sel_en and the fields of one frame. It is valid when sel_en != 0.
- Transfer: completes at an edge where (sel_en & out_ready) != 0. Ready bits of non-selected instances are ignored.
- Hold: while valid and not transferring, all output fields stay stable.
- Output stage refill, at an edge where the stage is empty or transferring:
  - if the FIFO is non-empty, load the FIFO head (pop);
  - else if an accepted offer is present, load it directly (bypass; FIFO untouched);
  - else clear sel_en to 0. Fields keep their last value.
- Latency: with stage and FIFO empty, an offer in cycle N is presented in cycle N+1, with sel_en and op_id aligned.
- Ordering: strict FIFO, across all instances.
- Push and pop in the same edge: fifo_level unchanged; read and write pointers both advance and wrap modulo FIFO_DEPTH.
- Total capacity: FIFO_DEPTH+1 frames.
- Reset mid-operation: all queued and presented frames are lost and outputs go to reset values immediately.

Test Plan:
- Defaults, out_ready=5'b11111. Offer load_in=5'b00100, frame_in=32'h0023_5A7C in cycle 0 -> cycle 1: sel_en=00100, addr=8'h11, wr_rd_s=1, wr_data=8'h5A, op_id=8'h7C. Cycle 2 (no offer): sel_en=0.
- out_ready=0, 6 back-to-back one-hot offers -> frames 1-5 accepted (1 presented, fifo_level=4, in_ready=0). Frame 6 dropped, drop_err pulses once. Outputs hold frame 1.
- Release out_ready for the selected instance only, one cycle each -> frames 1..5 presented in order, fifo_level 4,3,2,1,0, then sel_en=0.
- sel_en=00010 with out_ready=11101 -> no transfer for 10 cycles, outputs stable. Set out_ready[1]=1 -> next frame presented on the next cycle.
- Offer load_in=5'b01010 -> onehot_err pulses, fifo_level and outputs unchanged. Repeat with FIFO full -> only onehot_err pulses, not drop_err.
- FIFO_DEPTH=4 holding 3 frames, assert rst_n=0 mid-stream -> outputs 0 asynchronously. After release the FIFO is empty and in_ready=1.

Source files
------------

// File: rtl/frame_dispatch_q.sv
// Frame dispatch queue: slices incoming switch frames, queues them in order,
// and presents them one at a time to the selected switch instance.
module frame_dispatch_q #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int ID_WIDTH    = 8,
  parameter int FRAME_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_SW_INST-1:0]             load_in,
  input  logic [FRAME_WIDTH-1:0]             frame_in,
  output logic                               in_ready,
  output logic [NUM_SW_INST-1:0]             sel_en,
  output logic [7:0]                         addr,
  output logic [W_WIDTH-1:0]                 wr_data,
  output logic                               wr_rd_s,
  output logic [ID_WIDTH-1:0]                op_id,
  input  logic [NUM_SW_INST-1:0]             out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               drop_err,
  output logic                               onehot_err
);

  localparam int LVL_W    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int WD_LSB   = ID_WIDTH;
  localparam int WR_BIT   = ID_WIDTH + W_WIDTH;
  localparam int ADDR_LSB = WR_BIT + 1;
  localparam int USED_W   = ADDR_LSB + ADDR_WIDTH;

  // Field slicing of the offered frame
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [W_WIDTH-1:0]    wd_p0;
  logic                  wr_p0;
  logic [ID_WIDTH-1:0]   id_p0;

  assign id_p0   = frame_in[ID_WIDTH-1:0];
  assign wd_p0   = frame_in[WD_LSB +: W_WIDTH];
  assign wr_p0   = frame_in[WR_BIT];
  assign addr_p0 = frame_in[ADDR_LSB +: ADDR_WIDTH];

  generate
    if (FRAME_WIDTH > USED_W) begin : g_spare
      logic unused_frame_bits;
      assign unused_frame_bits = ^frame_in[FRAME_WIDTH-1:USED_W];
    end
  endgenerate

  logic [NUM_SW_INST-1:0] mem_sel  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  mem_addr [FIFO_DEPTH];
  logic [W_WIDTH-1:0]     mem_wd   [FIFO_DEPTH];
  logic                   mem_wr   [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]    mem_id   [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic offer, one_hot, multi_hot, accept, drop;
  logic stage_vld, xfer, refill, fifo_empty, pop, bypass, push;

  // Multi-hot is judged before fullness so a malformed offer never reports as a drop.
  assign offer      = |load_in;
  assign one_hot    = offer && ((load_in & (load_in - NUM_SW_INST'(1))) == '0);
  assign multi_hot  = offer && !one_hot;
  assign in_ready   = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign accept     = one_hot && in_ready;
  assign drop       = one_hot && !in_ready;

  assign stage_vld  = |sel_en;
  assign xfer       = |(sel_en & out_ready);
  assign refill     = !stage_vld || xfer;
  assign fifo_empty = (fifo_level == '0);
  assign pop        = refill && !fifo_empty;
  assign bypass     = refill && fifo_empty && accept;
  assign push       = accept && !bypass;

  // Queue storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sel[wr_ptr]  <= load_in;
      mem_addr[wr_ptr] <= addr_p0;
      mem_wd[wr_ptr]   <= wd_p0;
      mem_wr[wr_ptr]   <= wr_p0;
      mem_id[wr_ptr]   <= id_p0;
    end
  end

  // Pointers, occupancy, output stage and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      sel_en     <= '0;
      addr       <= '0;
      wr_data    <= '0;
      wr_rd_s    <= 1'b0;
      op_id      <= '0;
      drop_err   <= 1'b0;
      onehot_err <= 1'b0;
    end else begin
      drop_err   <= drop;
      onehot_err <= multi_hot;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase

      // Fields are left untouched when the stage empties out.
      if (refill) begin
        if (pop) begin
          sel_en  <= mem_sel[rd_ptr];
          addr    <= 8'(mem_addr[rd_ptr]);
          wr_data <= mem_wd[rd_ptr];
          wr_rd_s <= mem_wr[rd_ptr];
          op_id   <= mem_id[rd_ptr];
        end else if (bypass) begin
          sel_en  <= load_in;
          addr    <= 8'(addr_p0);
          wr_data <= wd_p0;
          wr_rd_s <= wr_p0;
          op_id   <= id_p0;
        end else begin
          sel_en  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_dispatch_q.sv
// Directed bench for frame_dispatch_q: vector table plus reset sequences.
module tb_frame_dispatch_q;

  logic       clk;
  logic       rst_n;
  logic [4:0] load_in;
  logic [31:0] frame_in;
  logic       in_ready;
  logic [4:0] sel_en;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic       wr_rd_s;
  logic [7:0] op_id;
  logic [4:0] out_ready;
  logic [2:0] fifo_level;
  logic       drop_err;
  logic       onehot_err;

  int n_chk  = 0;
  int n_fail = 0;

  frame_dispatch_q dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_in    (load_in),
    .frame_in   (frame_in),
    .in_ready   (in_ready),
    .sel_en     (sel_en),
    .addr       (addr),
    .wr_data    (wr_data),
    .wr_rd_s    (wr_rd_s),
    .op_id      (op_id),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .drop_err   (drop_err),
    .onehot_err (onehot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  load;
    logic [31:0] frame;
    logic [4:0]  ord;
    int          rep;
    logic [4:0]  sel;
    logic [7:0]  addr;
    logic        wr;
    logic [7:0]  wd;
    logic [7:0]  id;
    logic [2:0]  lvl;
    logic        rdy;
    logic        drop;
    logic        oh;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic [4:0] load, logic [31:0] frame, logic [4:0] ord, int rep,
                             logic [4:0] sel, logic [7:0] a, logic wr, logic [7:0] wd,
                             logic [7:0] id, logic [2:0] lvl, logic rdy, logic drop, logic oh);
    vec_t r;
    r.load = load; r.frame = frame; r.ord = ord; r.rep = rep;
    r.sel = sel; r.addr = a; r.wr = wr; r.wd = wd; r.id = id;
    r.lvl = lvl; r.rdy = rdy; r.drop = drop; r.oh = oh;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, " sel_en"},     32'(sel_en),     32'(e.sel));
    chk({tag, " addr"},       32'(addr),       32'(e.addr));
    chk({tag, " wr_rd_s"},    32'(wr_rd_s),    32'(e.wr));
    chk({tag, " wr_data"},    32'(wr_data),    32'(e.wd));
    chk({tag, " op_id"},      32'(op_id),      32'(e.id));
    chk({tag, " fifo_level"}, 32'(fifo_level), 32'(e.lvl));
    chk({tag, " in_ready"},   32'(in_ready),   32'(e.rdy));
    chk({tag, " drop_err"},   32'(drop_err),   32'(e.drop));
    chk({tag, " onehot_err"}, 32'(onehot_err), 32'(e.oh));
  endtask

  task automatic apply(input vec_t e, input string tag);
    load_in   = e.load;
    frame_in  = e.frame;
    out_ready = e.ord;
    @(posedge clk);
    #1;
    chk_all(tag, e);
  endtask

  vec_t zero_v;

  initial begin
    rst_n = 1'b0; load_in = '0; frame_in = '0; out_ready = '0;
    zero_v = v(5'b0, 32'h0, 5'b0, 1, 5'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);

    // Basic slicing and single-cycle presentation
    tv.push_back(v(5'b00100, 32'h0023_5A7C, 5'b11111, 1, 5'b00100, 8'h11, 1, 8'h5A, 8'h7C, 3'd0, 1, 0, 0));
    tv.push_back(v(5'b00000, 32'h0,         5'b11111, 1, 5'b00000, 8'h11, 1, 8'h5A, 8'h7C, 3'd0, 1, 0, 0));
    // Fill with outputs blocked; F1 carries junk in the ignored upper bits
    tv.push_back(v(5'b00001, 32'hFFC3_A111, 5'b00000, 1, 5'b00001, 8'h01, 1, 8'hA1, 8'h11, 3'd0, 1, 0, 0));
    tv.push_back(v(5'b00010, 32'h0004_A212, 5'b00000, 1, 5'b00001, 8'h01, 1, 8'hA1, 8'h11, 3'd1, 1, 0, 0));
    tv.push_back(v(5'b00100, 32'h0007_A313, 5'b00000, 1, 5'b00001, 8'h01, 1, 8'hA1, 8'h11, 3'd2, 1, 0, 0));
    tv.push_back(v(5'b01000, 32'h0008_A414, 5'b00000, 1, 5'b00001, 8'h01, 1, 8'hA1, 8'h11, 3'd3, 1, 0, 0));
    tv.push_back(v(5'b10000, 32'h000B_A515, 5'b00000, 1, 5'b00001, 8'h01, 1, 8'hA1, 8'h11, 3'd4, 0, 0, 0));
    // Offer while full and popping: still dropped
    tv.push_back(v(5'b00001, 32'h000C_A616, 5'b00001, 1, 5'b00010, 8'h02, 0, 8'hA2, 8'h12, 3'd3, 1, 1, 0));
    tv.push_back(v(5'b00001, 32'h000C_A616, 5'b00000, 1, 5'b00010, 8'h02, 0, 8'hA2, 8'h12, 3'd4, 0, 0, 0));
    // Multi-hot while full: onehot_err only
    tv.push_back(v(5'b01010, 32'h1234_5678, 5'b00000, 1, 5'b00010, 8'h02, 0, 8'hA2, 8'h12, 3'd4, 0, 0, 1));
    tv.push_back(v(5'b00000, 32'h0,         5'b00000, 1, 5'b00010, 8'h02, 0, 8'hA2, 8'h12, 3'd4, 0, 0, 0));
    // Non-selected ready bits must not transfer
    tv.push_back(v(5'b00000, 32'h0,         5'b11101, 10, 5'b00010, 8'h02, 0, 8'hA2, 8'h12, 3'd4, 0, 0, 0));
    // Drain in order
    tv.push_back(v(5'b00000, 32'h0,         5'b00010, 1, 5'b00100, 8'h03, 1, 8'hA3, 8'h13, 3'd3, 1, 0, 0));
    tv.push_back(v(5'b00000, 32'h0,         5'b00100, 1, 5'b01000, 8'h04, 0, 8'hA4, 8'h14, 3'd2, 1, 0, 0));
    tv.push_back(v(5'b00000, 32'h0,         5'b01000, 1, 5'b10000, 8'h05, 1, 8'hA5, 8'h15, 3'd1, 1, 0, 0));
    tv.push_back(v(5'b00000, 32'h0,         5'b10000, 1, 5'b00001, 8'h06, 0, 8'hA6, 8'h16, 3'd0, 1, 0, 0));
    tv.push_back(v(5'b00000, 32'h0,         5'b00001, 1, 5'b00000, 8'h06, 0, 8'hA6, 8'h16, 3'd0, 1, 0, 0));
    // Multi-hot while empty
    tv.push_back(v(5'b01010, 32'h0003_A111, 5'b00000, 1, 5'b00000, 8'h06, 0, 8'hA6, 8'h16, 3'd0, 1, 0, 1));
    tv.push_back(v(5'b00000, 32'h0,         5'b00000, 1, 5'b00000, 8'h06, 0, 8'hA6, 8'h16, 3'd0, 1, 0, 0));
    // Simultaneous push and pop across pointer wrap
    tv.push_back(v(5'b00001, 32'h0003_A111, 5'b00000, 1, 5'b00001, 8'h01, 1, 8'hA1, 8'h11, 3'd0, 1, 0, 0));
    tv.push_back(v(5'b00010, 32'h0004_A212, 5'b00000, 1, 5'b00001, 8'h01, 1, 8'hA1, 8'h11, 3'd1, 1, 0, 0));
    tv.push_back(v(5'b00100, 32'h0007_A313, 5'b00001, 1, 5'b00010, 8'h02, 0, 8'hA2, 8'h12, 3'd1, 1, 0, 0));
    tv.push_back(v(5'b01000, 32'h0008_A414, 5'b00010, 1, 5'b00100, 8'h03, 1, 8'hA3, 8'h13, 3'd1, 1, 0, 0));
    tv.push_back(v(5'b10000, 32'h000B_A515, 5'b00100, 1, 5'b01000, 8'h04, 0, 8'hA4, 8'h14, 3'd1, 1, 0, 0));
    tv.push_back(v(5'b00001, 32'h000C_A616, 5'b01000, 1, 5'b10000, 8'h05, 1, 8'hA5, 8'h15, 3'd1, 1, 0, 0));
    tv.push_back(v(5'b00000, 32'h0,         5'b10000, 1, 5'b00001, 8'h06, 0, 8'hA6, 8'h16, 3'd0, 1, 0, 0));
    tv.push_back(v(5'b00000, 32'h0,         5'b00001, 1, 5'b00000, 8'h06, 0, 8'hA6, 8'h16, 3'd0, 1, 0, 0));

    #2;
    chk_all("reset", zero_v);
    #10 rst_n = 1'b1;

    foreach (tv[i]) begin
      for (int r = 0; r < tv[i].rep; r++)
        apply(tv[i], $sformatf("r%0d", i));
    end

    // Stage plus three queued frames, then an asynchronous reset mid-cycle
    apply(v(5'b00001, 32'h0003_A111, 5'b00000, 1, 5'b00001, 8'h01, 1, 8'hA1, 8'h11, 3'd0, 1, 0, 0), "mr0");
    apply(v(5'b00010, 32'h0004_A212, 5'b00000, 1, 5'b00001, 8'h01, 1, 8'hA1, 8'h11, 3'd1, 1, 0, 0), "mr1");
    apply(v(5'b00100, 32'h0007_A313, 5'b00000, 1, 5'b00001, 8'h01, 1, 8'hA1, 8'h11, 3'd2, 1, 0, 0), "mr2");
    apply(v(5'b01000, 32'h0008_A414, 5'b00000, 1, 5'b00001, 8'h01, 1, 8'hA1, 8'h11, 3'd3, 1, 0, 0), "mr3");
    load_in = '0; frame_in = '0; out_ready = 5'b11111;
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", zero_v);
    #2 rst_n = 1'b1;
    apply(zero_v, "post_rst_idle");
    apply(v(5'b10000, 32'h000B_A515, 5'b00000, 1, 5'b10000, 8'h05, 1, 8'hA5, 8'h15, 3'd0, 1, 0, 0), "post_rst_offer");
    apply(v(5'b00000, 32'h0, 5'b10000, 1, 5'b00000, 8'h05, 1, 8'hA5, 8'h15, 3'd0, 1, 0, 0), "post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
